// File: rtl/sata_oob_pkg.sv
// sata_oob_pkg: shared definitions for the host COM out-of-band sequencer.
//   - hcom_state_e : FSM state encoding
//   - D10_2_PAT    : alternating ALIGN-phase bit pair, indexed by a 1-bit phase
//   - DEF_*        : default timing constants
//   - GAP_W        : width of the burst gap-length field
package sata_oob_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMRESET,
        WAIT_COMINIT,
        COMWAKE,
        WAIT_COMWAKE,
        SEND_ALIGN,
        LINK_UP,
        FAIL
    } hcom_state_e;

    // D10.2 is 0101010101 on the wire: one bit per clock, alternating.
    localparam logic [1:0] D10_2_PAT = 2'b01;

    localparam int DEF_BURST_CLKS     = 16;
    localparam int DEF_RESET_GAP_CLKS = 48;
    localparam int DEF_WAKE_GAP_CLKS  = 16;
    localparam int DEF_NBURSTS        = 6;
    localparam int DEF_TIMEOUT_CLKS   = 4096;
    localparam int DEF_MAX_RETRY      = 3;

    localparam int GAP_W = 16;

endpackage

// File: rtl/mdl_hcomfsm_if.sv
// mdl_hcomfsm_if: control bundle between the OOB FSM and the burst sequencer.
//   start   : pulse, begins a fresh NBURSTS burst/gap train (master -> slave)
//   gap_len : idle clocks after each burst, held stable for the whole train
//   data    : serial burst data (1 on the first burst clock, toggling)
//   idle    : high when the line must be electrically idle
//   done    : high in the final clock of the train
interface mdl_hcomfsm_if;
    import sata_oob_pkg::*;

    logic             start;
    logic [GAP_W-1:0] gap_len;
    logic             data;
    logic             idle;
    logic             done;

    modport master (output start, gap_len, input data, idle, done);
    modport slave  (input start, gap_len, output data, idle, done);
endinterface

// File: rtl/mdl_oobburst.sv
// mdl_oobburst: generates NBURSTS periods of BURST_CLKS toggling clocks
// followed by gap_len idle clocks. Shared by COMRESET and COMWAKE.
// Ports: clk, reset (sync, active-high), bus (mdl_hcomfsm_if.slave).
module mdl_oobburst
    import sata_oob_pkg::*;
#(
    parameter int BURST_CLKS = DEF_BURST_CLKS,
    parameter int NBURSTS    = DEF_NBURSTS
) (
    input  logic           clk,
    input  logic           reset,
    mdl_hcomfsm_if.slave   bus
);
    localparam int             IW       = $clog2(NBURSTS + 1);
    localparam logic [GAP_W:0] BL       = (GAP_W+1)'(BURST_CLKS);
    localparam logic [GAP_W:0] ONE      = (GAP_W+1)'(1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NBURSTS - 1);

    logic           active;
    logic [GAP_W:0] pos;    // clock within the current burst+gap period
    logic [IW-1:0]  idx;    // burst number
    logic           in_burst;
    logic           period_end;

    assign in_burst   = active && (pos < BL);
    assign period_end = (pos + ONE) == (BL + {1'b0, bus.gap_len});
    assign bus.data   = in_burst && !pos[0];
    assign bus.idle   = !in_burst;
    assign bus.done   = active && period_end && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            pos    <= '0;
            idx    <= '0;
        end else if (bus.start) begin
            active <= 1'b1;
            pos    <= '0;
            idx    <= '0;
        end else if (active) begin
            if (period_end) begin
                pos <= '0;
                if (idx == LAST_IDX) active <= 1'b0;
                else                 idx    <= idx + IW'(1);
            end else begin
                pos <= pos + ONE;
            end
        end
    end
endmodule

// File: rtl/mdl_hcomfsm.sv
// mdl_hcomfsm: SATA host OOB sequencer (COMRESET, COMWAKE, ALIGN, link up).
// Ports: i_txclk clock; i_reset sync active-high; i_start begins sequence;
//   i_cominit_det / i_comwake_det / i_rx_align device events; i_tx link bit;
//   o_tx_p / o_tx_n differential out; o_link_up; o_fail (retries exhausted).
// Config: define HCOM_TIMEOUT_EN to enable wait-state timeouts and the
//   retry counter; otherwise waits are unbounded and o_fail is tied 0.
module mdl_hcomfsm
    import sata_oob_pkg::*;
#(
    parameter int BURST_CLKS     = DEF_BURST_CLKS,
    parameter int RESET_GAP_CLKS = DEF_RESET_GAP_CLKS,
    parameter int WAKE_GAP_CLKS  = DEF_WAKE_GAP_CLKS,
    parameter int NBURSTS        = DEF_NBURSTS,
    parameter int TIMEOUT_CLKS   = DEF_TIMEOUT_CLKS,
    parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
    input  logic i_txclk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_cominit_det,
    input  logic i_comwake_det,
    input  logic i_rx_align,
    input  logic i_tx,
    output logic o_tx_p,
    output logic o_tx_n,
    output logic o_link_up,
    output logic o_fail
);
    hcom_state_e state, state_n;
    logic        tx_q;
    logic        align_ph;
    logic        timeout;
    logic        retry_last;

    mdl_hcomfsm_if bb ();

    mdl_oobburst #(.BURST_CLKS(BURST_CLKS), .NBURSTS(NBURSTS)) u_burst (
        .clk   (i_txclk),
        .reset (i_reset),
        .bus   (bb.slave)
    );

    assign bb.gap_len = (state == COMRESET) ? GAP_W'(RESET_GAP_CLKS)
                                            : GAP_W'(WAKE_GAP_CLKS);
    // Every entry into a burst state starts a fresh train.
    assign bb.start   = (state_n != state) && (state_n inside {COMRESET, COMWAKE});

`ifdef HCOM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [TW-1:0] tmr;
    logic [RW-1:0] retry;
    logic          waiting;
    logic          to_fire;

    assign waiting    = state inside {WAIT_COMINIT, WAIT_COMWAKE, SEND_ALIGN};
    assign timeout    = waiting && (tmr == TW'(TIMEOUT_CLKS - 1));
    assign retry_last = (retry == RW'(MAX_RETRY - 1));
    // A detect in the timeout cycle wins, so only count when the timeout
    // actually steers the FSM.
    assign to_fire    = timeout && (state_n inside {COMRESET, FAIL});
    assign o_fail     = (state == FAIL);

    always_ff @(posedge i_txclk) begin
        if (i_reset) begin
            tmr   <= '0;
            retry <= '0;
        end else begin
            tmr <= (state_n != state || !waiting) ? '0 : tmr + TW'(1);
            if (state_n == LINK_UP && state != LINK_UP) retry <= '0;
            else if (to_fire)                           retry <= retry + RW'(1);
        end
    end
`else
    localparam int unused_cfg = TIMEOUT_CLKS + MAX_RETRY;
    assign timeout    = 1'b0;
    assign retry_last = 1'b0;
    assign o_fail     = 1'b0;
`endif

    always_ff @(posedge i_txclk) begin
        if (i_reset) begin
            state    <= IDLE;
            tx_q     <= 1'b0;
            align_ph <= 1'b0;
        end else begin
            state    <= state_n;
            tx_q     <= i_tx;
            align_ph <= (state == SEND_ALIGN) ? ~align_ph : 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:         if (i_start) state_n = COMRESET;
            COMRESET:     if (bb.done) state_n = WAIT_COMINIT;
            WAIT_COMINIT: if (i_cominit_det) state_n = COMWAKE;
                          else if (timeout)  state_n = retry_last ? FAIL : COMRESET;
            COMWAKE:      if (bb.done) state_n = WAIT_COMWAKE;
            WAIT_COMWAKE: if (i_comwake_det) state_n = SEND_ALIGN;
                          else if (timeout)  state_n = retry_last ? FAIL : COMRESET;
            SEND_ALIGN:   if (i_rx_align)    state_n = LINK_UP;
                          else if (timeout)  state_n = retry_last ? FAIL : COMRESET;
            LINK_UP:      if (i_cominit_det) state_n = COMWAKE;
            FAIL:         state_n = FAIL;
            default:      state_n = IDLE;
        endcase
    end

    always_comb begin
        o_tx_p    = 1'b0;
        o_tx_n    = 1'b0;
        o_link_up = 1'b0;
        case (state)
            COMRESET, COMWAKE: begin
                o_tx_p = bb.data;
                o_tx_n = !bb.idle && !bb.data;
            end
            SEND_ALIGN: begin
                o_tx_p = D10_2_PAT[align_ph];
                o_tx_n = ~D10_2_PAT[align_ph];
            end
            LINK_UP: begin
                o_tx_p    = tx_q;
                o_tx_n    = ~tx_q;
                o_link_up = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mdl_hcomfsm.sv
// tb_mdl_hcomfsm: self-checking bench for mdl_hcomfsm (default parameters)
// plus a short standalone check of mdl_oobburst through mdl_hcomfsm_if.
// Expected waveforms come from the OOB timing rules: burst position
// m = k mod (16+gap), o_tx_p = 1 on even m < 16, o_tx_n = 1 on odd m < 16.
module tb_mdl_hcomfsm;
    localparam int B  = 16;
    localparam int NB = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, cominit = 1'b0, comwake = 1'b0, rx_align = 1'b0, tx = 1'b0;
    logic tx_p, tx_n, link_up, fail;
    logic last_tx = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mdl_hcomfsm dut (
        .i_txclk(clk), .i_reset(rst), .i_start(start),
        .i_cominit_det(cominit), .i_comwake_det(comwake), .i_rx_align(rx_align),
        .i_tx(tx), .o_tx_p(tx_p), .o_tx_n(tx_n), .o_link_up(link_up), .o_fail(fail)
    );

    mdl_hcomfsm_if bif ();
    mdl_oobburst #(.BURST_CLKS(4), .NBURSTS(2)) u_unit (
        .clk(clk), .reset(rst), .bus(bif.slave)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        start = 1'b0; cominit = 1'b0; comwake = 1'b0; rx_align = 1'b0;
    endtask

    // Randomise inputs; bits set in hold0 force {start,align,comwake,cominit} low.
    task automatic noise(input logic [3:0] hold0);
        start    = hold0[3] ? 1'b0 : 1'($urandom_range(0, 1));
        rx_align = hold0[2] ? 1'b0 : 1'($urandom_range(0, 1));
        comwake  = hold0[1] ? 1'b0 : 1'($urandom_range(0, 1));
        cominit  = hold0[0] ? 1'b0 : 1'($urandom_range(0, 1));
        tx       = 1'($urandom_range(0, 1));
        last_tx  = tx;
    endtask

    // Checks ncyc clocks of a burst train starting at its first clock.
    task automatic run_oob(input int gap, input int ncyc, input string nm);
        int   m, act, bursts;
        logic ep, en, prev;
        act = 0; bursts = 0; prev = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            m  = k % (B + gap);
            ep = (m < B) && (m % 2 == 0);
            en = (m < B) && !ep;
            tests++;
            if ({tx_p, tx_n, link_up, fail} !== {ep, en, 2'b00}) begin
                fails++;
                $display("FAIL %s k=%0d: got %b want %b", nm, k,
                         {tx_p, tx_n, link_up, fail}, {ep, en, 2'b00});
            end
            if (tx_p | tx_n) begin
                act++;
                if (!prev) bursts++;
            end
            prev = tx_p | tx_n;
            noise(4'b0000);
            tick;
        end
        quiet;
        if (ncyc == NB * (B + gap)) begin
            tests++;
            if (bursts != NB) begin
                fails++; $display("FAIL %s_bursts: got %0d want %0d", nm, bursts, NB);
            end
            tests++;
            if (act != NB * B) begin
                fails++; $display("FAIL %s_active: got %0d want %0d", nm, act, NB * B);
            end
        end
    endtask

    task automatic wait_idle(input int n, input logic [3:0] hold0, input string nm);
        for (int k = 0; k < n; k++) begin
            tests++;
            if ({tx_p, tx_n, link_up, fail} !== 4'b0000) begin
                fails++;
                $display("FAIL %s k=%0d: got %b want 0000", nm, k, {tx_p, tx_n, link_up, fail});
            end
            noise(hold0);
            tick;
        end
        quiet;
    endtask

    task automatic do_reset;
        quiet;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic do_start;
        quiet;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        tick;
        tests++;
        if ({tx_p, tx_n, link_up, fail} !== 4'b0000) begin
            fails++; $display("FAIL reset_state: got %b want 0000", {tx_p, tx_n, link_up, fail});
        end
        wait_idle(8, 4'b1000, "idle_after_reset");
    endtask

    task automatic test_burst_unit;
        logic [2:0] exp;
        int m;
        bif.gap_len = 16'd3;
        bif.start   = 1'b1;
        tick;
        bif.start   = 1'b0;
        for (int k = 0; k < 15; k++) begin
            m   = k % 7;
            exp = {(k < 14) && (m < 4) && (m % 2 == 0), !((k < 14) && (m < 4)), k == 13};
            tests++;
            if ({bif.data, bif.idle, bif.done} !== exp) begin
                fails++;
                $display("FAIL burst_unit k=%0d: got %b want %b", k, {bif.data, bif.idle, bif.done}, exp);
            end
            tick;
        end
    endtask

    task automatic test_link_bringup(input string nm);
        int   n;
        logic prevp;
        do_start;
        run_oob(48, NB * (B + 48), {nm, "_comreset"});
        wait_idle(int'($urandom_range(0, 20)), 4'b1001, {nm, "_wait_cominit"});
        cominit = 1'b1;
        tick;
        cominit = 1'b0;
        run_oob(16, NB * (B + 16), {nm, "_comwake"});
        wait_idle(int'($urandom_range(0, 20)), 4'b1010, {nm, "_wait_comwake"});
        comwake = 1'b1;
        tick;
        comwake = 1'b0;
        n = int'($urandom_range(3, 20));
        prevp = 1'b0;
        for (int i = 0; i < n; i++) begin
            tests++;
            if (link_up !== 1'b0 || fail !== 1'b0 || tx_n !== ~tx_p || (i > 0 && tx_p === prevp)) begin
                fails++;
                $display("FAIL %s_align i=%0d: got p=%b n=%b lu=%b f=%b want alternating, lu=0",
                         nm, i, tx_p, tx_n, link_up, fail);
            end
            prevp = tx_p;
            noise(4'b0100);
            tick;
        end
        rx_align = 1'b1;
        tick;
        quiet;
        tests++;
        if ({tx_p, tx_n, link_up, fail} !== {last_tx, ~last_tx, 2'b10}) begin
            fails++;
            $display("FAIL %s_link_up: got %b want %b", nm, {tx_p, tx_n, link_up, fail},
                     {last_tx, ~last_tx, 2'b10});
        end
    endtask

    task automatic test_passthrough;
        logic       exp;
        logic [2:0] pat;
        pat = 3'b101;
        exp = last_tx;
        for (int i = 0; i < 24; i++) begin
            tests++;
            if ({tx_p, tx_n, link_up, fail} !== {exp, ~exp, 2'b10}) begin
                fails++;
                $display("FAIL passthrough i=%0d: got %b want %b", i, {tx_p, tx_n, link_up, fail},
                         {exp, ~exp, 2'b10});
            end
            noise(4'b0001);
            if (i < 3) tx = pat[2 - i];
            last_tx = tx;
            exp = tx;
            tick;
        end
        quiet;
        cominit = 1'b1;
        tick;
        cominit = 1'b0;
        run_oob(16, NB * (B + 16), "relink_comwake");
        wait_idle(5, 4'b1010, "relink_wait");
    endtask

    task automatic test_reset_mid_comwake;
        do_reset;
        do_start;
        run_oob(48, NB * (B + 48), "mid_comreset");
        cominit = 1'b1;
        tick;
        cominit = 1'b0;
        run_oob(16, 100, "mid_comwake");
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++;
        if ({tx_p, tx_n, link_up, fail} !== 4'b0000) begin
            fails++; $display("FAIL abort_reset: got %b want 0000", {tx_p, tx_n, link_up, fail});
        end
        wait_idle(10, 4'b1000, "post_abort");
        test_link_bringup("restart");
    endtask

`ifdef HCOM_TIMEOUT_EN
    task automatic test_timeout_fail;
        do_reset;
        do_start;
        for (int r = 0; r < 3; r++) begin
            run_oob(48, NB * (B + 48), "to_comreset");
            wait_idle(4096, 4'b1001, "to_wait");
        end
        for (int i = 0; i < 20; i++) begin
            tests++;
            if ({tx_p, tx_n, link_up, fail} !== 4'b0001) begin
                fails++; $display("FAIL fail_hold i=%0d: got %b want 0001", i, {tx_p, tx_n, link_up, fail});
            end
            noise(4'b0000);
            tick;
        end
        quiet;
    endtask

    task automatic test_detect_on_timeout;
        do_reset;
        do_start;
        run_oob(48, NB * (B + 48), "dt_comreset1");
        wait_idle(4096, 4'b1001, "dt_timeout1");
        run_oob(48, NB * (B + 48), "dt_comreset2");
        wait_idle(4095, 4'b1001, "dt_pre");
        cominit = 1'b1;
        tick;
        cominit = 1'b0;
        run_oob(16, NB * (B + 16), "dt_comwake");
        wait_idle(4096, 4'b1010, "dt_timeout2");
        run_oob(48, NB * (B + 48), "dt_comreset3");
        wait_idle(4096, 4'b1001, "dt_timeout3");
        tests++;
        if ({tx_p, tx_n, link_up, fail} !== 4'b0001) begin
            fails++; $display("FAIL dt_fail: got %b want 0001", {tx_p, tx_n, link_up, fail});
        end
    endtask
`else
    task automatic test_no_timeout;
        cominit = 1'b1;
        tick;
        cominit = 1'b0;
        run_oob(16, NB * (B + 16), "nt_comwake");
        wait_idle(4200, 4'b1010, "nt_wait");
        comwake = 1'b1;
        tick;
        comwake = 1'b0;
        tests++;
        if (tx_n !== ~tx_p || link_up !== 1'b0 || fail !== 1'b0) begin
            fails++; $display("FAIL nt_align: got %b want differential, lu=0 f=0", {tx_p, tx_n, link_up, fail});
        end
    endtask
`endif

    initial begin
        bif.start   = 1'b0;
        bif.gap_len = 16'd3;
        test_reset;
        test_burst_unit;
        test_link_bringup("bringup");
        test_passthrough;
        test_reset_mid_comwake;
`ifdef HCOM_TIMEOUT_EN
        test_timeout_fail;
        test_detect_on_timeout;
`else
        test_no_timeout;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
